svm_recall_sequencer: RTL
=========================

// Module: svm_recall_sequencer
// PURPOSE
//  Sequences the sign-magnitude SVM recall datapath over a bank of up to MAX_SV support-vector pairs.
//  Per pair: two 7x7 products, signed and summed into one running decision value.
//  Sits behind the user-logic slave registers. Software loads the SV bank and writes the feature vector,
//  then pulses start and polls busy/done/result.
//  Replaces single-pair combinational recall with a multi-pair, cycle-accumulated decision.
// PARAMETERS
//  MAX_SV  16  number of support-vector pairs held in the internal bank
//  SV_AW   4   SV bank address width; MAX_SV == 2**SV_AW
//  ACC_W   20  signed two's-complement accumulator width; must be >= 16+SV_AW
// PORTS
//  Bus2IP_Clk    in   1         single clock; all state on rising edge
//  Bus2IP_Reset  in   1         synchronous, active-high reset
//  sv_wr_en      in   1         write one SV pair into bank
//  sv_wr_addr    in   SV_AW     bank index
//  sv_wr_data    in   16        {sv1[7:0], sv2[7:0]}; bit7 = sign (1 = neg), [6:0] = magnitude
//  num_sv        in   SV_AW+1   pairs to evaluate; sampled at start
//  feat          in   14        {f1[6:0], f2[6:0]} unsigned feature; sampled at start
//  start         in   1         launch recall (level sampled in IDLE only)
//  busy          out  1         recall in progress
//  done          out  1         one-cycle pulse: acc_out/result valid
//  result        out  1         class: 1 if decision >= 0, else 0
//  acc_out       out  ACC_W     signed decision value, held until next done
//  bias          in   ACC_W     signed bias (only with SVM_BIAS_EN)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, result = 0; acc_out = 0; SV bank not cleared.
//  FSM:
//    IDLE: start=1 -> latch feat and num_sv (clamped to MAX_SV), idx=0, acc=init.
//          Goes to RUN, or to FIN if num_sv==0.
//    RUN:  per cycle acc += term(idx), idx++; after the num_sv-th accumulate -> FIN.
//    FIN:  acc_out=acc, result=~acc[ACC_W-1], done=1 for one cycle, busy=0 -> IDLE.
//  busy = 1 in RUN and FIN-entry, i.e. the cycle after start is sampled through the last accumulate.
//  busy = 0 when done = 1.
//  Latency: done is high N+1 cycles after the edge sampling start (N = clamped num_sv). num_sv==0 -> 1 cycle.
//  term(i):
//    p1 = f1*sv1[6:0], p2 = f2*sv2[6:0] (14b unsigned each).
//    Each is negated if its sign bit = 1, sign-extended to ACC_W, then summed.
//    -0 (0x80) contributes 0.
//  Arithmetic wraps mod 2**ACC_W; with default widths overflow is impossible (max |sum| = 516128).
//  start while busy: ignored, no queueing. start held high in IDLE after done: relaunches next cycle.
//  sv_wr_en while busy: write dropped (bank frozen during recall). Write in IDLE takes effect next cycle.
//  Write same cycle as start: write performed, but the recall reads the new value only if the address
//  has not yet been passed.
//  Reset mid-operation: abort, no done pulse, return to IDLE next cycle, outputs to reset values.
// CONFIGURATION
//  SVM_BIAS_EN defined:
//    bias port present; acc initialised to bias at start.
//    Decision = bias + sum(term); num_sv==0 -> acc_out = bias.
//  SVM_BIAS_EN undefined:
//    bias port absent; acc initialised to 0.
// TESTING
//  1. Assert Bus2IP_Reset 2 cycles mid-idle -> busy=done=result=0, acc_out=0.
//  2. bank[0]={0x05,0x03}, feat={2,3}, num_sv=1, start -> done 2 cycles later, acc_out=19, result=1.
//  3. bank[0]={0x85,0x03}, feat={4,3}, num_sv=1 -> acc_out=-11, result=0.
//  4. All 16 entries {0x7F,0x7F}, feat={127,127}, num_sv=16 -> done at +17, acc_out=516128, result=1.
//     start pulsed mid-run is ignored (exactly one done).
//  5. bank[0]={0x80,0x00}, num_sv=1 -> acc_out=0, result=1.
//     num_sv=0 -> done at +1, acc_out=0. num_sv=20 -> treated as 16.
//  6. Reset at cycle 5 of test 4 -> busy=0 next cycle, no done.
//     Rerun test 2 -> 19. With SVM_BIAS_EN, bias=-20 -> acc_out=-1, result=0.

Source files
------------

// File: rtl/svm_recall_sequencer_if.sv
// Register-side bundle of the SVM recall sequencer: bank writes, launch, status, decision.
// With SVM_BIAS_EN defined the bundle also carries the signed bias.
interface svm_recall_sequencer_if #(
    parameter int SV_AW = 4,
    parameter int ACC_W = 20
);
    logic             sv_wr_en;
    logic [SV_AW-1:0] sv_wr_addr;
    logic [15:0]      sv_wr_data;
    logic [SV_AW:0]   num_sv;
    logic [13:0]      feat;
    logic             start;
    logic             busy;
    logic             done;
    logic             result;
    logic [ACC_W-1:0] acc_out;
`ifdef SVM_BIAS_EN
    logic [ACC_W-1:0] bias;
`endif

    modport master (
`ifdef SVM_BIAS_EN
        output bias,
`endif
        output sv_wr_en, sv_wr_addr, sv_wr_data,
        output num_sv, feat, start,
        input  busy, done, result, acc_out
    );

    modport slave (
`ifdef SVM_BIAS_EN
        input  bias,
`endif
        input  sv_wr_en, sv_wr_addr, sv_wr_data,
        input  num_sv, feat, start,
        output busy, done, result, acc_out
    );
endinterface

// File: rtl/svm_recall_sequencer.sv
// Multi-pair sign-magnitude SVM recall: one support-vector pair accumulated per cycle.
// Optional SVM_BIAS_EN: accumulator is preloaded from the bias port at start.
module svm_recall_sequencer #(
    parameter int MAX_SV = 16,
    parameter int SV_AW  = 4,
    parameter int ACC_W  = 20
) (
    input logic Bus2IP_Clk,
    input logic Bus2IP_Reset,
    svm_recall_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t state, state_nxt;

    logic [15:0]             bank [MAX_SV];
    logic [SV_AW-1:0]        idx;
    logic [SV_AW:0]          rem;
    logic [SV_AW:0]          n_clamp;
    logic [6:0]              f1, f2;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_init;
    logic signed [ACC_W-1:0] t1, t2, term;
    logic [15:0]             sv;
    logic [13:0]             p1, p2;
    logic                    done_r, result_r;
    logic [ACC_W-1:0]        acc_out_r;

    assign n_clamp = (bus.num_sv > (SV_AW+1)'(MAX_SV)) ?
                     (SV_AW+1)'(MAX_SV) : bus.num_sv;

`ifdef SVM_BIAS_EN
    assign acc_init = bus.bias;
`else
    assign acc_init = '0;
`endif

    // Bank is frozen while a recall is in flight and never cleared by reset
    always_ff @(posedge Bus2IP_Clk) begin
        if (bus.sv_wr_en && state == IDLE)
            bank[bus.sv_wr_addr] <= bus.sv_wr_data;
    end

    always_comb begin
        sv = bank[idx];
        p1 = 14'(f1) * 14'(sv[14:8]);
        p2 = 14'(f2) * 14'(sv[6:0]);
        t1 = ACC_W'(p1);
        t2 = ACC_W'(p2);
        if (sv[15]) t1 = -t1;
        if (sv[7])  t2 = -t2;
        term = t1 + t2;
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (n_clamp == '0) ? FIN : RUN;
            end
            RUN: begin
                if (rem == (SV_AW+1)'(1))
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            done_r    <= 1'b0;
            result_r  <= 1'b0;
            acc_out_r <= '0;
            acc       <= '0;
            idx       <= '0;
            rem       <= '0;
            f1        <= '0;
            f2        <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        f1  <= bus.feat[13:7];
                        f2  <= bus.feat[6:0];
                        rem <= n_clamp;
                        idx <= '0;
                        acc <= acc_init;
                    end
                end
                RUN: begin
                    acc <= acc + term;
                    idx <= idx + 1'b1;
                    rem <= rem - 1'b1;
                end
                FIN: begin
                    acc_out_r <= acc;
                    result_r  <= ~acc[ACC_W-1];
                    done_r    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.result  = result_r;
    assign bus.acc_out = acc_out_r;
endmodule
